// File: rtl/dp_mem_master.sv
// dp_mem_master: two-channel registered initiator for the 4x16 dual-port data memory.
// Define DP_MEM_MASTER_RR_EN for round-robin write-conflict arbitration (default: channel 0 wins).
module dp_mem_master #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req_valid_0,
    input  logic          req_valid_1,
    output logic          req_ready_0,
    output logic          req_ready_1,
    input  logic          req_we_0,
    input  logic          req_we_1,
    input  logic [AW-1:0] req_addr_0,
    input  logic [AW-1:0] req_addr_1,
    input  logic [DW-1:0] req_wdata_0,
    input  logic [DW-1:0] req_wdata_1,
    output logic          rsp_valid_0,
    output logic          rsp_valid_1,
    output logic [DW-1:0] rsp_data_0,
    output logic [DW-1:0] rsp_data_1,
    output logic          wE_0,
    output logic          wE_1,
    output logic [AW-1:0] Addr_0,
    output logic [AW-1:0] Addr_1,
    output logic [DW-1:0] WrData_0,
    output logic [DW-1:0] WrData_1,
    input  logic [DW-1:0] RdData_0,
    input  logic [DW-1:0] RdData_1
);
    // Handshake: a request is taken when valid && ready at the rising edge; ready is combinational
    // and only drops for the losing channel of a same-address dual write.
    logic conflict;
    logic acc_0;
    logic acc_1;
    logic rd_s1_0;
    logic rd_s2_0;
    logic rd_s1_1;
    logic rd_s2_1;

    assign conflict = req_valid_0 && req_valid_1 && req_we_0 && req_we_1 &&
                      (req_addr_0 == req_addr_1);

`ifdef DP_MEM_MASTER_RR_EN
    logic prio;

    assign req_ready_0 = reset_n && !(conflict && prio);
    assign req_ready_1 = reset_n && !(conflict && !prio);

    // The winner is always valid in a conflict, so every conflict cycle is a resolution.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (conflict) begin
            prio <= !prio;
        end
    end
`else
    assign req_ready_0 = reset_n;
    assign req_ready_1 = reset_n && !conflict;
`endif

    assign acc_0 = req_valid_0 && req_ready_0;
    assign acc_1 = req_valid_1 && req_ready_1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wE_0        <= 1'b0;
            wE_1        <= 1'b0;
            Addr_0      <= '0;
            Addr_1      <= '0;
            WrData_0    <= '0;
            WrData_1    <= '0;
            rd_s1_0     <= 1'b0;
            rd_s2_0     <= 1'b0;
            rd_s1_1     <= 1'b0;
            rd_s2_1     <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_data_0  <= '0;
            rsp_data_1  <= '0;
        end else begin
            wE_0 <= acc_0 && req_we_0;
            wE_1 <= acc_1 && req_we_1;
            if (acc_0) begin
                Addr_0   <= req_addr_0;
                WrData_0 <= req_wdata_0;
            end
            if (acc_1) begin
                Addr_1   <= req_addr_1;
                WrData_1 <= req_wdata_1;
            end
            // Stage 1 covers the memory's input register, stage 2 its read-data output.
            rd_s1_0     <= acc_0 && !req_we_0;
            rd_s1_1     <= acc_1 && !req_we_1;
            rd_s2_0     <= rd_s1_0;
            rd_s2_1     <= rd_s1_1;
            rsp_valid_0 <= rd_s2_0;
            rsp_valid_1 <= rd_s2_1;
            rsp_data_0  <= RdData_0;
            rsp_data_1  <= RdData_1;
        end
    end
endmodule

// File: tb/tb_dp_mem_master.sv
// Directed bench for dp_mem_master with a behavioural write-first 4x16 dual-port memory.
// Expectations follow DP_MEM_MASTER_RR_EN when it is defined for the build.
module tb_dp_mem_master;
    logic       clk;
    logic       reset_n;
    logic       req_valid_0, req_valid_1;
    logic       req_ready_0, req_ready_1;
    logic       req_we_0, req_we_1;
    logic [3:0] req_addr_0, req_addr_1;
    logic [3:0] req_wdata_0, req_wdata_1;
    logic       rsp_valid_0, rsp_valid_1;
    logic [3:0] rsp_data_0, rsp_data_1;
    logic       wE_0, wE_1;
    logic [3:0] Addr_0, Addr_1;
    logic [3:0] WrData_0, WrData_1;
    logic [3:0] RdData_0, RdData_1;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [1:0] rdy;
    logic [1:0] exp_rdy;
    logic [3:0] exp_final;
    logic [3:0] exp_q_0[$];
    logic [3:0] exp_q_1[$];
    logic [3:0] mem [16] = '{default: 4'h0};
    logic       dual_wr_seen = 1'b0;

    dp_mem_master #(.AW(4), .DW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_we_0(req_we_0), .req_we_1(req_we_1),
        .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
        .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
        .wE_0(wE_0), .wE_1(wE_1),
        .Addr_0(Addr_0), .Addr_1(Addr_1),
        .WrData_0(WrData_0), .WrData_1(WrData_1),
        .RdData_0(RdData_0), .RdData_1(RdData_1)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: registered inputs, write-first across both ports
    always @(posedge clk) begin
        if (wE_0) RdData_0 <= WrData_0;
        else if (wE_1 && Addr_1 == Addr_0) RdData_0 <= WrData_1;
        else RdData_0 <= mem[Addr_0];
        if (wE_1) RdData_1 <= WrData_1;
        else if (wE_0 && Addr_0 == Addr_1) RdData_1 <= WrData_0;
        else RdData_1 <= mem[Addr_1];
        if (wE_0) mem[Addr_0] <= WrData_0;
        if (wE_1) mem[Addr_1] <= WrData_1;
        if (wE_0 && wE_1 && Addr_0 == Addr_1) dual_wr_seen <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver: apply one cycle of requests from a negedge, record ready, return at the next negedge
    task automatic step(input logic v0, input logic we0, input logic [3:0] a0, input logic [3:0] d0,
                        input logic [3:0] e0,
                        input logic v1, input logic we1, input logic [3:0] a1, input logic [3:0] d1,
                        input logic [3:0] e1);
        req_valid_0 = v0; req_we_0 = we0; req_addr_0 = a0; req_wdata_0 = d0;
        req_valid_1 = v1; req_we_1 = we1; req_addr_1 = a1; req_wdata_1 = d1;
        #1;
        rdy = {req_ready_1, req_ready_0};
        if (v0 && req_ready_0 && !we0) exp_q_0.push_back(e0);
        if (v1 && req_ready_1 && !we1) exp_q_1.push_back(e1);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
    endtask

    // Scoreboard: every response pulse must match the oldest expected read
    always @(negedge clk) begin
        if (rsp_valid_0 === 1'b1) begin
            if (exp_q_0.size() == 0) check_eq("rsp_unexpected_0", 1, 0);
            else check_eq("rsp_data_0", rsp_data_0, exp_q_0.pop_front());
        end
        if (rsp_valid_1 === 1'b1) begin
            if (exp_q_1.size() == 0) check_eq("rsp_unexpected_1", 1, 0);
            else check_eq("rsp_data_1", rsp_data_1, exp_q_1.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        req_valid_0 = 1'b0; req_we_0 = 1'b0; req_addr_0 = 4'h0; req_wdata_0 = 4'h0;
        req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = 4'h0; req_wdata_1 = 4'h0;
        @(negedge clk);
        #1;
        check_eq("rst_ready_low", {req_ready_1, req_ready_0}, 2'b00);
        @(negedge clk);
        check_eq("rst_mem_side", {wE_1, wE_0, Addr_1, Addr_0, WrData_1, WrData_0}, 0);
        check_eq("rst_rsp", {rsp_valid_1, rsp_valid_0, rsp_data_1, rsp_data_0}, 0);
        reset_n = 1'b1;
        #1;
        check_eq("idle_ready", {req_ready_1, req_ready_0}, 2'b11);

        // Write on ch0, read back on ch1 one cycle later
        step(1'b1, 1'b1, 4'h3, 4'hA, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check_eq("t1_wr_drive", {wE_0, Addr_0, WrData_0}, {1'b1, 4'h3, 4'hA});
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, 4'h0, 4'hA);
        check_eq("t1_ch0_hold", {wE_0, Addr_0, WrData_0}, {1'b0, 4'h3, 4'hA});
        check_eq("t1_rd_drive", {wE_1, Addr_1}, {1'b0, 4'h3});
        idle();
        check_eq("t1_rsp_early", rsp_valid_1, 1'b0);
        idle();
        check_eq("t1_rsp", {rsp_valid_1, rsp_data_1}, {1'b1, 4'hA});
        idle();
        check_eq("t1_rsp_pulse", rsp_valid_1, 1'b0);

        // Preload two addresses, then dual read
        step(1'b1, 1'b1, 4'h5, 4'h6, 4'h0, 1'b1, 1'b1, 4'h9, 4'h9, 4'h0);
        check_eq("t2_dual_wr_rdy", rdy, 2'b11);
        step(1'b1, 1'b0, 4'h5, 4'h0, 4'h6, 1'b1, 1'b0, 4'h9, 4'h0, 4'h9);
        idle();
        idle();
        check_eq("t2_dual_rd", {rsp_valid_1, rsp_valid_0, rsp_data_1, rsp_data_0},
                 {1'b1, 1'b1, 4'h9, 4'h6});

        // Same-address write and read in one cycle is not a conflict
        step(1'b1, 1'b1, 4'h4, 4'hC, 4'h0, 1'b1, 1'b0, 4'h4, 4'h0, 4'hC);
        check_eq("t3_rw_rdy", rdy, 2'b11);
        idle();
        idle();
        check_eq("t3_rw_rsp", {rsp_valid_1, rsp_data_1}, {1'b1, 4'hC});

        // Write conflict on addr 7: ch0 first, ch1 holds and goes next
        step(1'b1, 1'b1, 4'h7, 4'h1, 4'h0, 1'b1, 1'b1, 4'h7, 4'h2, 4'h0);
        check_eq("t4_conf_rdy", rdy, 2'b01);
        check_eq("t4_conf_drive", {wE_1, wE_0, Addr_0, WrData_0}, {1'b0, 1'b1, 4'h7, 4'h1});
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h7, 4'h2, 4'h0);
        check_eq("t4_loser_rdy", rdy[1], 1'b1);
        check_eq("t4_loser_drive", {wE_1, wE_0, Addr_1, WrData_1}, {1'b1, 1'b0, 4'h7, 4'h2});
        step(1'b1, 1'b0, 4'h7, 4'h0, 4'h2, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        idle();
        idle();
        check_eq("t4_readback", {rsp_valid_0, rsp_data_0}, {1'b1, 4'h2});

        // Reset while a read is in flight
        step(1'b1, 1'b0, 4'h3, 4'h0, 4'hA, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b0;
        exp_q_0.delete();
        exp_q_1.delete();
        idle();
        check_eq("t6_rst_ready", rdy, 2'b00);
        check_eq("t6_rst_mem_side", {wE_1, wE_0, Addr_1, Addr_0, WrData_1, WrData_0}, 0);
        check_eq("t6_rst_rsp", {rsp_valid_1, rsp_valid_0, rsp_data_1, rsp_data_0}, 0);
        reset_n = 1'b1;
        idle();
        check_eq("t6_no_rsp_a", {rsp_valid_1, rsp_valid_0}, 2'b00);
        idle();
        check_eq("t6_no_rsp_b", {rsp_valid_1, rsp_valid_0}, 2'b00);

        // Four consecutive conflicts on addr 2 (priority starts at ch0 after reset)
        for (int i = 0; i < 4; i++) begin
`ifdef DP_MEM_MASTER_RR_EN
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
            step(1'b1, 1'b1, 4'h2, 4'(i + 1), 4'h0, 1'b1, 1'b1, 4'h2, 4'(i + 5), 4'h0);
            check_eq($sformatf("t5_rdy_%0d", i), rdy, exp_rdy);
            check_eq($sformatf("t5_we_%0d", i), {wE_1, wE_0}, exp_rdy);
        end
`ifdef DP_MEM_MASTER_RR_EN
        exp_final = 4'h8;
`else
        exp_final = 4'h4;
`endif
        step(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 4'h0, exp_final);
        idle();
        idle();
        check_eq("t5_readback", {rsp_valid_1, rsp_data_1}, {1'b1, exp_final});
        idle();

        check_eq("no_dual_write", dual_wr_seen, 1'b0);
        check_eq("q0_drained", exp_q_0.size(), 0);
        check_eq("q1_drained", exp_q_1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
